// File: rtl/ddc_frame_sequencer.sv
// ddc_frame_sequencer
// Packs digitizer event words into frames and publishes each finished frame to
// the HPS-facing PIO registers. The published set stays stable until HPS
// acknowledges it by toggling hps_read_bit (either edge).
//
// Optional build macro: DDC_SEQ_DROP_EN
//   defined   - evt_ready stays 1 after reset; words arriving while the fill
//               buffer is FULL are discarded and each discarded frame bumps a
//               saturating 8-bit drop count.
//   undefined - backpressure through evt_ready; drop count reads 0.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   evt_valid/evt_ready event word handshake: a word transfers on a rising
//                       clk edge where evt_valid and evt_ready are both 1;
//                       evt_data/evt_last qualify the word
//   hps_read_bit        HPS ack toggle, asynchronous to clk
//   pio_data            published frame, word i at [i*DATA_W +: DATA_W]
//   pio_time            timestamp of the first word of the published frame
//   pio_status          {seq[15:0], word_count[7:0], drop_count[7:0]}
//   frame_pending       published frame not yet acknowledged
//   dbg_state           {publish state (1=WAIT_ACK), fill state (1=FULL)}
module ddc_frame_sequencer #(
  parameter int FRAME_WORDS = 32,
  parameter int DATA_W      = 32,
  parameter int TIME_W      = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          evt_valid,
  input  logic [DATA_W-1:0]             evt_data,
  input  logic                          evt_last,
  output logic                          evt_ready,
  input  logic                          hps_read_bit,
  output logic [FRAME_WORDS*DATA_W-1:0] pio_data,
  output logic [TIME_W-1:0]             pio_time,
  output logic [31:0]                   pio_status,
  output logic                          frame_pending,
  output logic [1:0]                    dbg_state
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);

  typedef enum logic {FILL_S = 1'b0, FULL_S = 1'b1} fill_e;
  typedef enum logic {IDLE_S = 1'b0, WAIT_ACK_S = 1'b1} pub_e;

  fill_e fill_q, fill_d;
  pub_e  pub_q, pub_d;

  logic [TIME_W-1:0]             timer_q, timer_d;
  logic [FRAME_WORDS*DATA_W-1:0] buf_q, buf_d;
  // In FILL: next write index. In FULL: number of valid words in the frame.
  logic [CNT_W-1:0]              wcnt_q, wcnt_d;
  logic [TIME_W-1:0]             fill_time_q, fill_time_d;
  logic [FRAME_WORDS*DATA_W-1:0] pio_data_q, pio_data_d;
  logic [TIME_W-1:0]             pio_time_q, pio_time_d;
  logic [7:0]                    pio_cnt_q, pio_cnt_d;
  logic [15:0]                   seq_q, seq_d;
  logic                          rdy_en_q;
  logic [SYNC_STAGES-1:0]        sync_q, sync_d;
  logic                          prev_q;
  // Marks when the synchronizer and prev sample hold real samples of
  // hps_read_bit, so a pin that is already high at reset release is not an ack.
  logic [SYNC_STAGES:0]          armed_q, armed_d;
  logic [7:0]                    drop_q;

  logic fill_accept, complete, ack, publish;

  assign ack         = armed_q[SYNC_STAGES] & (sync_q[SYNC_STAGES-1] ^ prev_q);
  assign fill_accept = evt_valid & evt_ready & (fill_q == FILL_S);
  assign complete    = fill_accept & ((wcnt_q == LAST_IDX) | evt_last);
  // Publishing only looks at the registered IDLE state, so an ack arriving
  // together with a completion takes effect first and the publish follows
  // on the next cycle.
  assign publish     = (pub_q == IDLE_S) & ((fill_q == FULL_S) | complete);
  assign sync_d      = {sync_q[SYNC_STAGES-2:0], hps_read_bit};
  assign armed_d     = {armed_q[SYNC_STAGES-1:0], 1'b1};
  assign timer_d     = timer_q + TIME_W'(1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= FILL_S;
      pub_q  <= IDLE_S;
    end else begin
      fill_q <= fill_d;
      pub_q  <= pub_d;
    end
  end

  // Next-state logic
  always_comb begin
    fill_d = fill_q;
    pub_d  = pub_q;
    if (complete) fill_d = FULL_S;
    if (publish)  fill_d = FILL_S;
    case (pub_q)
      IDLE_S:     if (publish) pub_d = WAIT_ACK_S;
      WAIT_ACK_S: if (ack)     pub_d = IDLE_S;
      default:    pub_d = IDLE_S;
    endcase
  end

  // State-derived outputs
  always_comb begin
`ifdef DDC_SEQ_DROP_EN
    evt_ready = rdy_en_q;
`else
    evt_ready = rdy_en_q & (fill_q == FILL_S);
`endif
    frame_pending = (pub_q == WAIT_ACK_S);
    dbg_state     = {pub_q, fill_q};
  end

  // Datapath: fill buffer write, publish copy, buffer clear
  always_comb begin
    buf_d       = buf_q;
    wcnt_d      = wcnt_q;
    fill_time_d = fill_time_q;
    pio_data_d  = pio_data_q;
    pio_time_d  = pio_time_q;
    pio_cnt_d   = pio_cnt_q;
    seq_d       = seq_q;
    if (fill_accept) begin
      if (wcnt_q == '0) fill_time_d = timer_q;
      buf_d[int'(wcnt_q)*DATA_W +: DATA_W] = evt_data;
      wcnt_d = wcnt_q + CNT_W'(1);
    end
    // The _d values already include a word completing this cycle.
    if (publish) begin
      pio_data_d = buf_d;
      pio_time_d = fill_time_d;
      pio_cnt_d  = 8'(wcnt_d);
      seq_d      = seq_q + 16'd1;
      buf_d      = '0;
      wcnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q     <= '0;
      buf_q       <= '0;
      wcnt_q      <= '0;
      fill_time_q <= '0;
      pio_data_q  <= '0;
      pio_time_q  <= '0;
      pio_cnt_q   <= '0;
      seq_q       <= '0;
      rdy_en_q    <= 1'b0;
      sync_q      <= '0;
      prev_q      <= 1'b0;
      armed_q     <= '0;
    end else begin
      timer_q     <= timer_d;
      buf_q       <= buf_d;
      wcnt_q      <= wcnt_d;
      fill_time_q <= fill_time_d;
      pio_data_q  <= pio_data_d;
      pio_time_q  <= pio_time_d;
      pio_cnt_q   <= pio_cnt_d;
      seq_q       <= seq_d;
      rdy_en_q    <= 1'b1;
      sync_q      <= sync_d;
      prev_q      <= sync_q[SYNC_STAGES-1];
      armed_q     <= armed_d;
    end
  end

`ifdef DDC_SEQ_DROP_EN
  // Words arriving while FULL are swallowed; dcnt tracks position inside the
  // discarded frame so its completing word can be counted.
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [7:0]       drop_d;
  logic             drop_accept, drop_done;

  assign drop_accept = evt_valid & evt_ready & (fill_q == FULL_S);
  assign drop_done   = drop_accept & ((dcnt_q == LAST_IDX) | evt_last);

  always_comb begin
    dcnt_d = dcnt_q;
    drop_d = drop_q;
    if (drop_done) begin
      dcnt_d = '0;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end else if (drop_accept) begin
      dcnt_d = dcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt_q <= '0;
      drop_q <= '0;
    end else begin
      dcnt_q <= dcnt_d;
      drop_q <= drop_d;
    end
  end
`else
  assign drop_q = '0;
`endif

  assign pio_data   = pio_data_q;
  assign pio_time   = pio_time_q;
  assign pio_status = {seq_q, pio_cnt_q, drop_q};

endmodule

// File: tb/tb_ddc_frame_sequencer.sv
module tb_ddc_frame_sequencer;
  localparam int FW = 32;
  localparam int DW = 32;
  localparam int TW = 26;
  localparam int SS = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             evt_valid;
  logic [DW-1:0]    evt_data;
  logic             evt_last;
  logic             evt_ready;
  logic             hps_read_bit;
  logic [FW*DW-1:0] pio_data;
  logic [TW-1:0]    pio_time;
  logic [31:0]      pio_status;
  logic             frame_pending;
  logic [1:0]       dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_t;
  int ready_low;

  ddc_frame_sequencer #(
    .FRAME_WORDS(FW), .DATA_W(DW), .TIME_W(TW), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_last(evt_last),
    .evt_ready(evt_ready), .hps_read_bit(hps_read_bit),
    .pio_data(pio_data), .pio_time(pio_time), .pio_status(pio_status),
    .frame_pending(frame_pending), .dbg_state(dbg_state)
  );

  // Clock / reset-relative cycle count (the timestamp reference)
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Words 0..n-1 must be base+i, all later words 0.
  task automatic check_frame(input string tag, input int n, input logic [31:0] base);
    for (int i = 0; i < FW; i++)
      check($sformatf("%s_w%0d", tag, i), 64'(pio_data[i*DW +: DW]),
            (i < n) ? 64'(base + 32'(i)) : 64'h0);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one word at a negedge; it transfers on the following posedge.
  task automatic send(input logic [31:0] d, input logic last);
    evt_valid = 1'b1;
    evt_data  = d;
    evt_last  = last;
    @(negedge clk);
    evt_valid = 1'b0;
    evt_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; evt_valid = 1'b0; evt_data = '0; evt_last = 1'b0; hps_read_bit = 1'b0;
    step(2);
    check("rst_ready", 64'(evt_ready), 64'd0);
    check("rst_pending", 64'(frame_pending), 64'd0);
    check("rst_status", 64'(pio_status), 64'd0);
    check("rst_time", 64'(pio_time), 64'd0);
    check("rst_dbg", 64'(dbg_state), 64'd0);
    check_frame("rst_data", 0, 32'h0);
    reset = 1'b0;
    step(5);
    check("ready_after_rst", 64'(evt_ready), 64'd1);

    // Frame 1: 32 words, first word sampled at timer=5
    for (int i = 0; i < 32; i++) send(32'h100 + 32'(i), i == 31);
    check_frame("f1", 32, 32'h100);
    check("f1_time", 64'(pio_time), 64'd5);
    check("f1_status", 64'(pio_status), 64'h0001_2000);
    check("f1_pending", 64'(frame_pending), 64'd1);

    // Rising ack: clears pending after SYNC_STAGES+1 edges
    hps_read_bit = 1'b1;
    step(2);
    check("ack1_early", 64'(frame_pending), 64'd1);
    step(1);
    check("ack1_pending", 64'(frame_pending), 64'd0);

    // Frame 2: 3 words, ended early by evt_last
    exp_t = cyc;
    send(32'hA0, 1'b0); send(32'hA1, 1'b0); send(32'hA2, 1'b1);
    check_frame("f2", 3, 32'hA0);
    check("f2_time", 64'(pio_time), 64'(exp_t));
    check("f2_status", 64'(pio_status), 64'h0002_0300);
    check("f2_pending", 64'(frame_pending), 64'd1);

    // Frame 3 filled while frame 2 is pending
    exp_t = cyc;
    for (int i = 0; i < 32; i++) send(32'h200 + 32'(i), i == 31);
`ifndef DDC_SEQ_DROP_EN
    check("f3_ready_low", 64'(evt_ready), 64'd0);
`endif
    check("f3_dbg_full", 64'(dbg_state), 64'd3);
    check("f3_held_status", 64'(pio_status), 64'h0002_0300);
    check("f3_held_w0", 64'(pio_data[DW-1:0]), 64'hA0);
    check("f3_held_pending", 64'(frame_pending), 64'd1);

    // Falling ack: frame 3 appears SYNC_STAGES+2 edges after the toggle
    hps_read_bit = 1'b0;
    step(3);
    check("f3_not_yet", 64'(pio_status), 64'h0002_0300);
    step(1);
    check("f3_status", 64'(pio_status), 64'h0003_2000);
    check_frame("f3", 32, 32'h200);
    check("f3_time", 64'(pio_time), 64'(exp_t));
    check("f3_ready", 64'(evt_ready), 64'd1);
    check("f3_pending", 64'(frame_pending), 64'd1);

    // Ack frame 3, then toggle with nothing pending: no effect
    hps_read_bit = 1'b1;
    step(4);
    check("ack3_pending", 64'(frame_pending), 64'd0);
    hps_read_bit = 1'b0;
    step(5);
    check("idle_status", 64'(pio_status), 64'h0003_2000);
    check("idle_pending", 64'(frame_pending), 64'd0);
    check("idle_ready", 64'(evt_ready), 64'd1);
    check("idle_w0", 64'(pio_data[DW-1:0]), 64'h200);
    check("idle_dbg", 64'(dbg_state), 64'd0);

    // Frame 4: single word; later toggle back counts as its ack
    exp_t = cyc;
    send(32'hBEEF, 1'b1);
    check("f4_status", 64'(pio_status), 64'h0004_0100);
    check("f4_time", 64'(pio_time), 64'(exp_t));
    check("f4_w0", 64'(pio_data[DW-1:0]), 64'hBEEF);
    check("f4_w1", 64'(pio_data[2*DW-1:DW]), 64'h0);
    check("f4_pending", 64'(frame_pending), 64'd1);
    hps_read_bit = 1'b1;
    step(3);
    check("f4_acked", 64'(frame_pending), 64'd0);

    // Reset in the middle of a frame (hps_read_bit left high)
    for (int i = 0; i < 10; i++) send(32'h300 + 32'(i), 1'b0);
    evt_valid = 1'b1; evt_data = 32'h30A;
    reset = 1'b1;
    #1;
    check("mid_rst_status", 64'(pio_status), 64'd0);
    check("mid_rst_time", 64'(pio_time), 64'd0);
    check("mid_rst_w0", 64'(pio_data[DW-1:0]), 64'd0);
    check("mid_rst_pending", 64'(frame_pending), 64'd0);
    check("mid_rst_ready", 64'(evt_ready), 64'd0);
    evt_valid = 1'b0;
    step(1);
    reset = 1'b0;
    step(1);
    exp_t = cyc;
    send(32'hC0DE, 1'b1);
    check("r1_status", 64'(pio_status), 64'h0001_0100);
    check("r1_time", 64'(pio_time), 64'(exp_t));
    check("r1_w0", 64'(pio_data[DW-1:0]), 64'hC0DE);
    step(4);
    check("r1_no_spurious_ack", 64'(frame_pending), 64'd1);

`ifdef DDC_SEQ_DROP_EN
    // Fill a frame behind the pending one, then flood with 300 frames
    send(32'h400, 1'b0); send(32'h401, 1'b1);
    ready_low = 0;
    for (int k = 0; k < 300; k++) begin
      if (evt_ready !== 1'b1) ready_low++;
      send(32'h5000 + 32'(k), 1'b1);
    end
    check("drop_ready_high", 64'(ready_low), 64'd0);
    check("drop_status", 64'(pio_status), 64'h0001_01FF);
    hps_read_bit = 1'b0;
    step(4);
    check("drop_pub_status", 64'(pio_status), 64'h0002_02FF);
    check_frame("drop_f2", 2, 32'h400);
    check("drop_pub_pending", 64'(frame_pending), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
